bus_arbiter8: RTL and testbench

Round-robin arbiter and select generator for the shared 16-bit internal bus of the multicycle datapath. Up to eight requesters compete for the bus. The block grants one requester at a time and drives the 3-bit select of the 8:1 16-bit bus multiplexer so that the winner's word reaches the bus. It also bounds each tenure to MAX_HOLD transfer cycles, so no requester can starve the others.

---
 rtl/bus_arbiter8.sv | 50 +++++
 tb/tb_bus_arbiter8.sv | 111 +++++++++++
 2 files changed

// File: rtl/bus_arbiter8.sv
// bus_arbiter8: round-robin 8-way bus arbiter with bounded tenure and registered mux select
module bus_arbiter8 #(
  parameter int MAX_HOLD = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] req,
  input  logic [7:0] last,
  output logic [7:0] gnt,
  output logic [2:0] sel,
  output logic       bus_valid
);
  typedef enum logic {IDLE, GRANT} state_t;
  state_t state_q, state_d;
  logic [2:0] ptr_q, ptr_d, g_q, g_d, pick;
  logic [7:0] gnt_q, gnt_d, cnt_q, cnt_d, rot;
  logic rel;
  always_comb begin
    rot = 8'({req, req} >> ptr_q);
    pick = '0;
    for (int i = 7; i >= 0; i--) if (rot[i]) pick = ptr_q + 3'(i);
  end
  assign bus_valid = (state_q == GRANT) && req[g_q];
  // a withdrawn request releases without counting a transfer
  assign rel = (state_q == GRANT) && (!req[g_q] || last[g_q] || cnt_q == 8'(MAX_HOLD - 1));
  always_comb begin
    state_d = (state_q == IDLE) ? ((|req) ? GRANT : IDLE) : (rel ? IDLE : GRANT);
    g_d = (state_q == IDLE && |req) ? pick : g_q;
    gnt_d = (state_d == GRANT) ? 8'(1) << g_d : '0;
    cnt_d = (state_q == GRANT && !rel) ? cnt_q + 8'd1 : '0;
    ptr_d = rel ? g_q + 3'd1 : ptr_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      gnt_q <= '0;
      g_q <= '0;
      ptr_q <= '0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      gnt_q <= gnt_d;
      g_q <= g_d;
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
    end
  end
  assign gnt = gnt_q;
  assign sel = g_q;
endmodule

// File: tb/tb_bus_arbiter8.sv
// tb_bus_arbiter8: directed scoreboard bench for two bus_arbiter8 instances (MAX_HOLD 4 and 2)
module tb_bus_arbiter8;
  logic clk = 0, reset = 1;
  logic [7:0] req = 8'hFF, last = 8'h00;
  logic [7:0] gnt4, gnt2;
  logic [2:0] sel4, sel2;
  logic bv4, bv2;
  int checks = 0, errors = 0;
  typedef struct {
    logic [7:0] g;
    logic [2:0] s;
    logic b;
    bit d2;
    string nm;
  } exp_t;
  exp_t q[$];

  bus_arbiter8 #(.MAX_HOLD(4)) u4 (.clk(clk), .reset(reset), .req(req), .last(last),
    .gnt(gnt4), .sel(sel4), .bus_valid(bv4));
  bus_arbiter8 #(.MAX_HOLD(2)) u2 (.clk(clk), .reset(reset), .req(req), .last(last),
    .gnt(gnt2), .sel(sel2), .bus_valid(bv2));

  always #5 clk = ~clk;

  task automatic step(input logic [7:0] r, input logic [7:0] l, input logic rs,
                      input logic [7:0] eg, input logic [2:0] es, input logic eb,
                      input bit d2, input string nm);
    exp_t e;
    @(negedge clk);
    req = r;
    last = l;
    reset = rs;
    e.g = eg; e.s = es; e.b = eb; e.d2 = d2; e.nm = nm;
    q.push_back(e);
  endtask

  initial begin
    forever begin
      @(negedge clk);
      #1;
      while (q.size() > 0) begin
        exp_t e;
        logic [7:0] ag;
        logic [2:0] as;
        logic ab;
        e = q.pop_front();
        ag = e.d2 ? gnt2 : gnt4;
        as = e.d2 ? sel2 : sel4;
        ab = e.d2 ? bv2 : bv4;
        checks++;
        if (ag !== e.g || as !== e.s || ab !== e.b) begin
          errors++;
          $display("FAIL %s: got gnt=%h sel=%0d bv=%b want gnt=%h sel=%0d bv=%b",
                   e.nm, ag, as, ab, e.g, e.s, e.b);
        end
      end
    end
  end

  initial begin
    // reset held two cycles with all requests high
    step(8'hFF, 8'h00, 1, 8'h00, 3'd0, 0, 0, "rst_a");
    step(8'hFF, 8'h00, 0, 8'h00, 3'd0, 0, 0, "rst_b");
    step(8'hFF, 8'h00, 0, 8'h01, 3'd0, 1, 0, "first_gnt");
    step(8'h00, 8'h00, 1, 8'h01, 3'd0, 0, 0, "rst_c");
    // single requester 3, MAX_HOLD 4
    step(8'h08, 8'h00, 0, 8'h00, 3'd0, 0, 0, "single_idle");
    for (int i = 0; i < 4; i++) step(8'h08, 8'h00, 0, 8'h08, 3'd3, 1, 0, "single_hold1");
    step(8'h08, 8'h00, 0, 8'h00, 3'd3, 0, 0, "single_gap");
    for (int i = 0; i < 4; i++) step(8'h08, 8'h00, 0, 8'h08, 3'd3, 1, 0, "single_hold2");
    step(8'h00, 8'h00, 1, 8'h00, 3'd3, 0, 0, "single_end");
    // fairness on the MAX_HOLD 2 instance
    step(8'hFF, 8'h00, 0, 8'h00, 3'd0, 0, 1, "rr_idle");
    for (int k = 0; k < 9; k++) begin
      logic [2:0] kk;
      kk = 3'(k);
      step(8'hFF, 8'h00, 0, 8'(1) << kk, kk, 1, 1, "rr_xfer1");
      step(8'hFF, 8'h00, 0, 8'(1) << kk, kk, 1, 1, "rr_xfer2");
      step(8'hFF, 8'h00, 0, 8'h00, kk, 0, 1, "rr_gap");
    end
    step(8'h00, 8'h00, 1, 8'h02, 3'd1, 0, 1, "rr_end");
    // early release via last, non-granted last ignored, skip to requester 5
    step(8'h24, 8'h00, 0, 8'h00, 3'd0, 0, 0, "early_idle");
    step(8'h24, 8'h20, 0, 8'h04, 3'd2, 1, 0, "early_x1");
    step(8'h24, 8'h04, 0, 8'h04, 3'd2, 1, 0, "early_last");
    step(8'h24, 8'h00, 0, 8'h00, 3'd2, 0, 0, "early_gap");
    step(8'h24, 8'h00, 0, 8'h20, 3'd5, 1, 0, "skip_to5");
    step(8'h00, 8'h00, 1, 8'h20, 3'd5, 0, 0, "early_end");
    // withdrawal by requester 6
    step(8'h40, 8'h00, 0, 8'h00, 3'd0, 0, 0, "wd_idle");
    step(8'h01, 8'h40, 0, 8'h40, 3'd6, 0, 0, "wd_drop");
    step(8'h01, 8'h00, 0, 8'h00, 3'd6, 0, 0, "wd_gap");
    step(8'h01, 8'h00, 0, 8'h01, 3'd0, 1, 0, "wd_next");
    step(8'h00, 8'h00, 1, 8'h01, 3'd0, 0, 0, "wd_end");
    // reset in the middle of requester 5 tenure
    step(8'h20, 8'h00, 0, 8'h00, 3'd0, 0, 0, "mid_idle");
    step(8'h20, 8'h00, 0, 8'h20, 3'd5, 1, 0, "mid_x1");
    step(8'h20, 8'h00, 0, 8'h20, 3'd5, 1, 0, "mid_x2");
    step(8'h21, 8'h00, 1, 8'h20, 3'd5, 1, 0, "mid_rst");
    step(8'h21, 8'h00, 0, 8'h00, 3'd0, 0, 0, "mid_after");
    step(8'h21, 8'h00, 0, 8'h01, 3'd0, 1, 0, "mid_regrant");
    @(negedge clk);
    #2;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending want 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
